// File: rtl/parity_check.sv
// Receive-side parity checker: reassembles an LSB-first serial frame
// (DATA_WIDTH data bits plus one parity bit), then reports the word and a parity-error pulse.
module parity_check #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frm_start,
  input  logic                  bit_vld,
  input  logic                  bit_in,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_vld,
  output logic                  par_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_typ;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_err;

  // Same convention as the generator: the error is rx parity ^ data parity ^ type.
  function automatic logic par_error(input logic rx_bit, input logic data_par,
                                     input logic typ);
    return rx_bit ^ data_par ^ typ;
  endfunction

  // frm_start always wins over a coincident bit strobe.
  assign w_accept = bit_vld && !frm_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frm_start) begin
      w_state_nxt = DATA;
    end else begin
      unique case (r_state)
        DATA:    if (bit_vld && (r_cnt == LAST_BIT)) w_state_nxt = PARITY;
        PARITY:  if (bit_vld) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_done = (r_state == PARITY) && w_accept;
    w_err  = w_done && par_error(bit_in, r_par, r_typ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data   <= '0;
      data_vld <= 1'b0;
      par_err  <= 1'b0;
      busy     <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_typ    <= 1'b0;
    end else begin
      data_vld <= w_done;
      par_err  <= w_err;
      busy     <= (w_state_nxt != IDLE);
      if (w_done) p_data <= r_shift;
      if (frm_start) begin
        r_typ   <= par_typ;
        r_cnt   <= '0;
        r_par   <= 1'b0;
        r_shift <= '0;
      end else if ((r_state == DATA) && bit_vld) begin
        // Shift right, MSB-in: the first bit received ends up in bit 0.
        r_shift <= {bit_in, r_shift[DATA_WIDTH-1:1]};
        r_par   <= r_par ^ bit_in;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/parity_check.md
Name: parity_check

Overview:
Receive-side counterpart of the parity generator. It takes a serial, already-sampled bit stream (LSB-first data followed by one parity bit), reassembles the data word, and recomputes parity over it. It then reports the word together with a parity-error flag. It sits between the serial bit sampler and the receive data path; the parity convention matches the transmit-side generator exactly.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame, excluding the parity bit. Legal range is 2 to 32.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- frm_start, input, 1: one-cycle pulse marking the start of a new frame (start bit detected).
- bit_vld, input, 1: strobe indicating that bit_in carries a new sampled bit this cycle.
- bit_in, input, 1: sampled serial bit.
- par_typ, input, 1: parity type, 0 = EVEN_par, 1 = ODD_par. Sampled only on frm_start.
- p_data, output, DATA_WIDTH: reassembled data word. Holds its value until the next frame completes.
- data_vld, output, 1: one-cycle pulse marking p_data and par_err as valid.
- par_err, output, 1: one-cycle pulse, coincident with data_vld, asserted when the received parity bit is wrong.
- busy, output, 1: high while a frame is in progress (state DATA or PARITY).

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0, all of the following are 0: p_data, data_vld, par_err, busy, state (IDLE), bit counter, shift register, running parity, latched par_typ.
- Parity convention is identical to the generator:
  - expected parity bit = (^data) for EVEN_par, ~(^data) for ODD_par.
  - par_err = bit_in_parity XOR (^data) XOR par_typ_latched.
- State IDLE:
  - bit_vld is ignored.
  - On frm_start: latch par_typ, clear the counter and running parity, go to DATA.
- State DATA:
  - On bit_vld: shift right with bit_in entering at the MSB, so after DATA_WIDTH bits bit 0 holds the first bit received.
  - Also on bit_vld: running parity ^= bit_in, counter += 1.
  - On the DATA_WIDTH-th bit_vld, go to PARITY.
  - Cycles without bit_vld hold all state; gaps of any length are allowed.
- State PARITY:
  - On bit_vld: compute the error as above and go to IDLE.
  - In the next cycle: data_vld=1, par_err=error, and p_data is loaded from the shift register.
- Latency: data_vld rises exactly 1 clk after the cycle in which the parity bit's bit_vld is sampled. data_vld and par_err are each high for exactly one cycle.
- busy is registered. It is 1 from the cycle after frm_start until the cycle after the parity bit is accepted (it falls in the same cycle data_vld rises).
- frm_start in DATA or PARITY aborts the current frame:
  - no data_vld or par_err is produced, and p_data keeps its old value;
  - the block restarts in DATA with the newly latched par_typ.
- frm_start and bit_vld in the same cycle: frm_start wins and that bit_vld is ignored.
- frm_start in the same cycle as the parity bit_vld:
  - the frame is aborted, so no output pulse is produced;
  - the new frame starts.
- A change on par_typ mid-frame has no effect on the current frame.
- Reset asserted mid-frame:
  - all state and outputs clear immediately (asynchronously);
  - a frame that was in progress produces no output;
  - after reset release the block waits in IDLE for frm_start.
- The counter is sized ceil(log2(DATA_WIDTH+1)) bits and does not wrap within a frame.

Test Plan:
- Even parity, frm_start with par_typ=0, bits of 0xA5 LSB-first, then parity 0 → 1 cycle after the parity bit: data_vld=1, p_data=0xA5, par_err=0, busy falls.
- Odd parity, par_typ=1, data 0xA5: parity bit 1 → par_err=0; repeat with parity bit 0 → par_err=1, p_data=0xA5.
- Even parity, data 0x00, parity bit 1 → par_err=1. Data 0xFF, parity bit 0 → par_err=0. Insert 3-cycle gaps between bit_vld strobes; the result must be unchanged.
- Abort: start frame 0x3C, after 4 bits assert frm_start, then send full frame 0x81 with correct even parity → exactly one data_vld, with p_data=0x81 and par_err=0.
- Reset mid-frame: send 5 bits, pulse rst=0 for 2 cycles → all outputs 0 immediately. Further bit_vld without frm_start produces no data_vld. Then send a complete frame 0x5A (even, parity 0) → p_data=0x5A, par_err=0.
- Ignored inputs: toggle par_typ mid-frame (latched 0, data 0x0F, parity 0) → par_err=0. bit_vld while IDLE → busy stays 0 and no output.
